// File: rtl/pb_event_sequencer.sv
// Purpose: Avalon-MM master that drives a 1-bit pushbutton PIO (mask init, debounce, level re-read, edge clear) and emits qualified presses.
// Latency: init writes on cycles 1 and 2 after reset; irq seen in IDLE -> event_valid after DEBOUNCE_CYCLES+4 cycles.
// Backpressure: event_valid is held until event_ready; edges meanwhile merge in the PIO edge_capture register. Option macro: PB_SEQ_TIMESTAMP_EN.
module pb_event_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned DB_W            = 20,
  parameter int unsigned COUNT_W         = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  output logic [1:0]         pio_address,
  output logic               pio_chipselect,
  output logic               pio_write_n,
  output logic [31:0]        pio_writedata,
  input  logic [31:0]        pio_readdata,
  input  logic               pio_irq,
  output logic               event_valid,
  input  logic               event_ready,
  output logic [COUNT_W-1:0] press_count,
  output logic [7:0]         reject_count
`ifdef PB_SEQ_TIMESTAMP_EN
  ,
  output logic [31:0]        event_time
`endif
);

  typedef enum logic [2:0] {
    S_INIT_MASK,
    S_INIT_CLR,
    S_IDLE,
    S_DEBOUNCE,
    S_RD_REQ,
    S_RD_CAP,
    S_ACK,
    S_EMIT
  } state_t;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0]      A_DATA  = 2'd0;
  localparam logic [1:0]      A_MASK  = 2'd2;
  localparam logic [1:0]      A_EDGE  = 2'd3;

  state_t               state_q, state_d;
  logic                 init_go_q, init_go_d;
  logic [DB_W-1:0]      db_q, db_d;
  logic                 level_q, level_d;
  logic                 cs_q, cs_d;
  logic                 wn_q, wn_d;
  logic [1:0]           addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic                 evt_vld_q, evt_vld_d;
  logic [COUNT_W-1:0]   press_q, press_d;
  logic [7:0]           reject_q, reject_d;
  logic                 start_svc;

  // Only bit 0 of the PIO data register carries the button level.
  logic unused_rd;
  assign unused_rd = ^pio_readdata[31:1];

  assign start_svc = (state_q == S_IDLE) && pio_irq && enable;

  // Next-state, counters and the registered bus/event outputs.
  // Bus outputs are decoded from the next state so the registered strobe
  // lines up with the state that owns the access.
  always_comb begin
    state_d   = state_q;
    init_go_d = init_go_q;
    db_d      = db_q;
    level_d   = level_q;
    press_d   = press_q;
    reject_d  = reject_q;
    cs_d      = 1'b0;
    wn_d      = 1'b1;
    addr_d    = 2'd0;
    wdata_d   = 32'd0;
    evt_vld_d = 1'b0;

    case (state_q)
      // First cycle after reset only arms the mask write so it appears on cycle 1.
      S_INIT_MASK: begin
        if (!init_go_q) init_go_d = 1'b1;
        else            state_d   = S_INIT_CLR;
      end
      S_INIT_CLR: state_d = S_IDLE;
      S_IDLE: begin
        if (start_svc) begin
          state_d = S_DEBOUNCE;
          db_d    = '0;
        end
      end
      // pio_irq is deliberately ignored; bounces stay merged in edge_capture.
      S_DEBOUNCE: begin
        if (db_q == DB_LAST) state_d = S_RD_REQ;
        else                 db_d    = db_q + 1'b1;
      end
      S_RD_REQ: state_d = S_RD_CAP;
      S_RD_CAP: begin
        level_d = pio_readdata[0];
        state_d = S_ACK;
      end
      S_ACK: begin
        if (level_q) begin
          state_d = S_EMIT;
        end else begin
          if (reject_q != 8'hFF) reject_d = reject_q + 8'd1;
          state_d = S_IDLE;
        end
      end
      S_EMIT: begin
        if (event_ready) begin
          press_d = press_q + 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_INIT_MASK;
    endcase

    case (state_d)
      S_INIT_MASK: begin
        if (init_go_d) begin
          cs_d = 1'b1; wn_d = 1'b0; addr_d = A_MASK; wdata_d = 32'd1;
        end
      end
      S_INIT_CLR, S_ACK: begin
        cs_d = 1'b1; wn_d = 1'b0; addr_d = A_EDGE; wdata_d = 32'd1;
      end
      S_RD_REQ: begin
        cs_d = 1'b1; wn_d = 1'b1; addr_d = A_DATA;
      end
      S_EMIT:  evt_vld_d = 1'b1;
      default: ;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_INIT_MASK;
      init_go_q <= 1'b0;
      db_q      <= '0;
      level_q   <= 1'b0;
      cs_q      <= 1'b0;
      wn_q      <= 1'b1;
      addr_q    <= 2'd0;
      wdata_q   <= 32'd0;
      evt_vld_q <= 1'b0;
      press_q   <= '0;
      reject_q  <= 8'd0;
    end else begin
      state_q   <= state_d;
      init_go_q <= init_go_d;
      db_q      <= db_d;
      level_q   <= level_d;
      cs_q      <= cs_d;
      wn_q      <= wn_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      evt_vld_q <= evt_vld_d;
      press_q   <= press_d;
      reject_q  <= reject_d;
    end
  end

  assign pio_chipselect = cs_q;
  assign pio_write_n    = wn_q;
  assign pio_address    = addr_q;
  assign pio_writedata  = wdata_q;
  assign event_valid    = evt_vld_q;
  assign press_count    = press_q;
  assign reject_count   = reject_q;

`ifdef PB_SEQ_TIMESTAMP_EN
  logic [31:0] ts_q, ts_d;
  logic [31:0] evt_time_q, evt_time_d;

  // Free-running cycle counter; snapshot taken when a service starts.
  always_comb begin
    ts_d       = ts_q + 32'd1;
    evt_time_d = evt_time_q;
    if (start_svc) evt_time_d = ts_q;
  end

  // Timestamp registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts_q       <= 32'd0;
      evt_time_q <= 32'd0;
    end else begin
      ts_q       <= ts_d;
      evt_time_q <= evt_time_d;
    end
  end

  assign event_time = evt_time_q;
`endif

endmodule

// File: tb/tb_pb_event_sequencer.sv
// Testbench for pb_event_sequencer with DEBOUNCE_CYCLES = 4 and a behavioural PIO model.
// Table-driven init/pulse vectors, hand-written backpressure/enable/reset sequences, random pulses.
// Outputs are sampled 1 time unit after the rising edge; inputs are driven at the same point.
module tb_pb_event_sequencer;

  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b1;
  logic [1:0]  pio_address;
  logic        pio_chipselect;
  logic        pio_write_n;
  logic [31:0] pio_writedata;
  logic [31:0] pio_readdata;
  logic        pio_irq;
  logic        event_valid;
  logic        event_ready = 1'b0;
  logic [15:0] press_count;
  logic [7:0]  reject_count;
`ifdef PB_SEQ_TIMESTAMP_EN
  logic [31:0] event_time;
  int          tb_cyc;
  int          ts_exp;
`endif

  // PIO model state
  logic in_port = 1'b0;
  logic in_prev;
  logic edge_cap;
  logic irq_mask;

  int n_cmp = 0;
  int n_fail = 0;
  int hs_cnt = 0;
  int exp_press = 0;
  int exp_rej = 0;

  always #5 clk = ~clk;

  pb_event_sequencer #(.DEBOUNCE_CYCLES(DB), .DB_W(20), .COUNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .pio_address(pio_address), .pio_chipselect(pio_chipselect),
    .pio_write_n(pio_write_n), .pio_writedata(pio_writedata),
    .pio_readdata(pio_readdata), .pio_irq(pio_irq),
    .event_valid(event_valid), .event_ready(event_ready),
    .press_count(press_count), .reject_count(reject_count)
`ifdef PB_SEQ_TIMESTAMP_EN
    , .event_time(event_time)
`endif
  );

  // Pushbutton PIO: rising-edge capture, write-1-to-clear, registered readdata.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_prev      <= 1'b0;
      edge_cap     <= 1'b0;
      irq_mask     <= 1'b0;
      pio_readdata <= 32'd0;
    end else begin
      in_prev <= in_port;
      if (pio_chipselect && pio_write_n)
        pio_readdata <= (pio_address == 2'd0) ? {31'd0, in_port} :
                        (pio_address == 2'd2) ? {31'd0, irq_mask} :
                        (pio_address == 2'd3) ? {31'd0, edge_cap} : 32'd0;
      else
        pio_readdata <= 32'd0;
      if (pio_chipselect && !pio_write_n && pio_address == 2'd2)
        irq_mask <= pio_writedata[0];
      if (in_port && !in_prev)
        edge_cap <= 1'b1;
      else if (pio_chipselect && !pio_write_n && pio_address == 2'd3 && pio_writedata[0])
        edge_cap <= 1'b0;
    end
  end
  assign pio_irq = edge_cap & irq_mask;

`ifdef PB_SEQ_TIMESTAMP_EN
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) tb_cyc <= 0;
    else          tb_cyc <= tb_cyc + 1;
  end
`endif

  typedef struct {
    logic        cs;
    logic        wn;
    logic [1:0]  addr;
    logic [31:0] wd;
  } bus_vec_t;

  typedef struct {
    int hold;      // cycles in_port is high
    int exp_first; // step index where event_valid first seen (0 = never)
    int d_press;
    int d_rej;
  } pulse_vec_t;

  bus_vec_t   init_tbl[4];
  pulse_vec_t ptbl[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle: wait for the edge, sample event_valid, then drive this cycle's inputs.
  task automatic step(input logic inp, input logic rdy, output logic vld);
    @(posedge clk);
    #1;
    vld = event_valid;
    in_port = inp;
    event_ready = rdy;
    if (vld && rdy) hs_cnt++;
  endtask

  function automatic int sat_inc(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  task automatic check_counters(input string tag);
    check({tag, "_press"}, 32'(press_count), 32'(exp_press & 16'hFFFF));
    check({tag, "_reject"}, 32'(reject_count), 32'(exp_rej));
  endtask

  // Called 1 time unit after reset release: cycle 0 is before the first edge.
  task automatic check_init();
    for (int c = 0; c < 4; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      check($sformatf("init%0d_cs", c), 32'(pio_chipselect), 32'(init_tbl[c].cs));
      check($sformatf("init%0d_wn", c), 32'(pio_write_n), 32'(init_tbl[c].wn));
      check($sformatf("init%0d_addr", c), 32'(pio_address), 32'(init_tbl[c].addr));
      check($sformatf("init%0d_wdata", c), pio_writedata, init_tbl[c].wd);
    end
    check("init_valid", 32'(event_valid), 32'd0);
    check("init_mask", 32'(irq_mask), 32'd1);
    check_counters("init");
  endtask

  initial begin
    logic v, pv;
    int   first, rise2, hs0;
    bit   stable, cs_seen, long_p;
    int   hold;

    init_tbl[0] = '{cs: 1'b0, wn: 1'b1, addr: 2'd0, wd: 32'd0};
    init_tbl[1] = '{cs: 1'b1, wn: 1'b0, addr: 2'd2, wd: 32'd1};
    init_tbl[2] = '{cs: 1'b1, wn: 1'b0, addr: 2'd3, wd: 32'd1};
    init_tbl[3] = '{cs: 1'b0, wn: 1'b1, addr: 2'd0, wd: 32'd0};

    // Level is re-read DB+3 cycles after the edge: hold 6 is a glitch, hold 7 survives.
    ptbl[0] = '{hold: 1,  exp_first: 0,      d_press: 0, d_rej: 1};
    ptbl[1] = '{hold: 2,  exp_first: 0,      d_press: 0, d_rej: 1};
    ptbl[2] = '{hold: 6,  exp_first: 0,      d_press: 0, d_rej: 1};
    ptbl[3] = '{hold: 7,  exp_first: DB + 5, d_press: 1, d_rej: 0};
    ptbl[4] = '{hold: 20, exp_first: DB + 5, d_press: 1, d_rej: 0};

    // Reset and init sequence
    repeat (3) @(posedge clk);
    #1;
    check("reset_cs", 32'(pio_chipselect), 32'd0);
    check("reset_valid", 32'(event_valid), 32'd0);
    reset_n = 1'b1;
    check_init();

    // Pulse table with a ready consumer
    for (int i = 0; i < 5; i++) begin
      first = 0;
      hs0 = hs_cnt;
      for (int k = 0; k < 40; k++) begin
        step(k < ptbl[i].hold, 1'b1, v);
`ifdef PB_SEQ_TIMESTAMP_EN
        if (k == 1) ts_exp = tb_cyc;
        if (v && first == 0) check($sformatf("tbl%0d_evt_time", i), event_time, 32'(ts_exp));
`endif
        if (v && first == 0) first = k;
      end
      exp_press += ptbl[i].d_press;
      exp_rej = (ptbl[i].d_rej != 0) ? sat_inc(exp_rej) : exp_rej;
      check($sformatf("tbl%0d_first_valid", i), 32'(first), 32'(ptbl[i].exp_first));
      check($sformatf("tbl%0d_handshakes", i), 32'(hs_cnt - hs0), 32'(ptbl[i].d_press));
      check($sformatf("tbl%0d_edge_cap", i), 32'(edge_cap), 32'd0);
      check_counters($sformatf("tbl%0d", i));
    end

    // Event held under backpressure while a second press arrives
    first = 0; rise2 = 0; stable = 1'b1; pv = 1'b0;
    hs0 = hs_cnt;
    for (int k = 0; k < 120; k++) begin
      step((k < 12) || (k >= 15 && k < 95), k >= 60, v);
      if (v && first == 0) first = k;
      if (v && !pv && k > 60 && rise2 == 0) rise2 = k;
      if (k >= 10 && k <= 60 && !v) stable = 1'b0;
      pv = v;
    end
    exp_press += 2;
    check("hold_first_valid", 32'(first), 32'(DB + 5));
    check("hold_stable", 32'(stable), 32'd1);
    check("hold_second_valid", 32'(rise2), 32'(60 + DB + 5));
    check("hold_handshakes", 32'(hs_cnt - hs0), 32'd2);
    check_counters("hold");

    // Enable low: interrupt pending but not serviced until enable rises
    enable = 1'b0;
    first = 0; cs_seen = 1'b0;
    for (int k = 0; k < 80; k++) begin
      step(k < 70, 1'b1, v);
      if (k <= 30 && pio_chipselect) cs_seen = 1'b1;
      if (k == 30) enable = 1'b1;
      if (v && first == 0) first = k;
    end
    exp_press += 1;
    check("en_bus_idle", 32'(cs_seen), 32'd0);
    check("en_first_valid", 32'(first), 32'(30 + DB + 4));
    check_counters("en");

    // Random pulses, random consumer readiness
    for (int i = 0; i < 20; i++) begin
      long_p = ($urandom_range(0, 1) == 1);
      hold = long_p ? $urandom_range(12, 30) : $urandom_range(1, 3);
      hs0 = hs_cnt;
      for (int k = 0; k < hold + 60; k++)
        step(k < hold, $urandom_range(0, 1) == 1, v);
      if (long_p) exp_press += 1;
      else        exp_rej = sat_inc(exp_rej);
      check($sformatf("rnd%0d_handshakes", i), 32'(hs_cnt - hs0), 32'(long_p ? 1 : 0));
      check($sformatf("rnd%0d_edge_cap", i), 32'(edge_cap), 32'd0);
      check_counters($sformatf("rnd%0d", i));
    end

    // Reject counter saturation
    for (int i = 0; i < 260; i++) begin
      for (int k = 0; k < 14; k++) step(k < 1, 1'b1, v);
      exp_rej = sat_inc(exp_rej);
    end
    check_counters("sat");

    // Reset asserted during DEBOUNCE
    for (int k = 0; k < 4; k++) step(1'b1, 1'b1, v);
    reset_n = 1'b0;
    in_port = 1'b0;
    #1;
    exp_press = 0;
    exp_rej = 0;
    check("rst_cs", 32'(pio_chipselect), 32'd0);
    check("rst_wn", 32'(pio_write_n), 32'd1);
    check("rst_addr", 32'(pio_address), 32'd0);
    check("rst_wdata", pio_writedata, 32'd0);
    check("rst_valid", 32'(event_valid), 32'd0);
    check_counters("rst");
`ifdef PB_SEQ_TIMESTAMP_EN
    check("rst_evt_time", event_time, 32'd0);
`endif
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    check_init();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
